wide_add_sequencer: RTL
=======================

// Module: wide_add_sequencer
// PURPOSE
// Computes W = N*CHUNKS-bit add/subtract by reusing one external N-bit ripple adder
// (instance parameter N) over CHUNKS cycles, least significant slice first.
// Drives the adder slice operands and carry-in, and captures its sum and carry-out.
// Sits between a requester (valid/ready in) and a consumer (valid/ready out) in the ALU datapath.
// PARAMETERS
// N       8  width of the shared adder slice (must equal the adder instance's N), N>=2
// CHUNKS  4  number of slices per operation, CHUNKS>=1; W = N*CHUNKS
// PORTS
// clk        in   1  single clock, all state updates on posedge
// rst_n      in   1  asynchronous, active-low reset
// in_valid   in   1  request present
// in_ready   out  1  sequencer can accept (IDLE only)
// a          in   W  operand A
// b          in   W  operand B
// sub        in   1  1: compute A-B, 0: compute A+B
// out_valid  out  1  result/flags valid (DONE)
// out_ready  in   1  consumer takes result
// result     out  W  sum/difference, registered
// cout       out  1  final carry out (for sub: 1 = no borrow)
// overflow   out  1  two's-complement signed overflow
// add_a      out  N  slice operand A to adder
// add_b      out  N  slice operand B to adder (already inverted when sub)
// add_cin    out  1  slice carry-in to adder
// add_result in   N  adder sum, combinational from add_a/add_b/add_cin
// add_cout   in   1  adder carry-out
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, result=0, cout=0, overflow=0,
//   out_valid=0; in_ready=1 once rst_n=1. Reset mid-operation aborts the op and discards latched operands.
// - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE when idx==CHUNKS-1;
//   DONE -> IDLE on out_valid&&out_ready.
// - IDLE accept edge: latch opA=a, opB = sub ? ~b : b; carry=sub; idx=0; clear result.
// - RUN: add_a=opA[idx*N +: N], add_b=opB[idx*N +: N], add_cin=carry. Each edge:
//   result[idx*N +: N] <= add_result; carry <= add_cout; idx <= idx+1.
// - At the last slice edge: cout <= add_cout;
//   overflow <= (opA[W-1] ~^ opB[W-1]) & (add_result[N-1] ^ opA[W-1]).
// - In IDLE and DONE, add_a=0, add_b=0, add_cin=0.
// - Latency: out_valid is high in the cycle after the CHUNKS-th RUN edge, i.e. CHUNKS
//   edges after the accept edge. CHUNKS=1 gives a single RUN cycle.
// - in_ready=1 only in IDLE. in_valid during RUN/DONE is ignored, and a, b, sub are not sampled.
// - DONE: out_valid=1. result, cout and overflow are held stable until the handshake.
//   out_ready=0 stalls indefinitely. in_ready returns high the cycle after the out handshake.
//   There is no same-cycle turnaround.
// - out_ready while not DONE: no effect. result keeps its last value after the handshake
//   until the next accept.
// - Arithmetic is modulo 2^W; no saturation.
// TESTING (N=8, CHUNKS=4)
// - add 0x000000FF+0x00000001 -> result 0x00000100, cout=0, overflow=0, out_valid 4 edges after accept
// - add 0xFFFFFFFF+0x00000001 -> result 0x00000000, cout=1, overflow=0 (carry ripples all slices)
// - add 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1; sub 0x80000000-1 -> 0x7FFFFFFF, cout=1, overflow=1
// - sub 0x00000000-0x00000001 -> 0xFFFFFFFF, cout=0 (borrow), overflow=0
// - out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; new in_valid with other
//   operands during RUN/DONE is not accepted and does not disturb the result
// - rst_n pulsed low after 2 RUN edges -> all outputs 0 immediately, in_ready=1 after release;
//   next op 0x12345678+0x11111111 -> 0x23456789

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: W = N*CHUNKS bit add/subtract built by stepping one
// external N-bit adder slice over CHUNKS cycles, least significant slice first.
// Valid/ready on both sides; result, cout and overflow are registered and held
// until the consumer takes them.
module wide_add_sequencer #(
   parameter int N      = 8,
   parameter int CHUNKS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*CHUNKS-1:0] a,
   input  logic [N*CHUNKS-1:0] b,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*CHUNKS-1:0] result,
   output logic                cout,
   output logic                overflow,
   output logic [N-1:0]        add_a,
   output logic [N-1:0]        add_b,
   output logic                add_cin,
   input  logic [N-1:0]        add_result,
   input  logic                add_cout
);

   localparam int W    = N * CHUNKS;
   localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [IDXW-1:0] idx;
   logic            carry;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;          // already inverted for subtraction
   logic [W-1:0]    result_reg;
   logic            cout_reg;
   logic            overflow_reg;
   logic            out_valid_reg;
   logic            in_ready_reg;

   // Operand slices, one per chunk, so the slice select is a plain array index.
   logic [N-1:0] a_slice [CHUNKS];
   logic [N-1:0] b_slice [CHUNKS];

   generate
      for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_slice
         assign a_slice[gi] = op_a[gi*N +: N];
         assign b_slice[gi] = op_b[gi*N +: N];
      end
   endgenerate

   // Adder slice is only driven while running; it sees zeros otherwise.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_slice[idx];
         add_b   = b_slice[idx];
         add_cin = carry;
      end
   end

   // Sequencer FSM: accept, step through slices, hold the result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         carry         <= 1'b0;
         op_a          <= '0;
         op_b          <= '0;
         result_reg    <= '0;
         cout_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a         <= a;
                  op_b         <= sub ? ~b : b;
                  carry        <= sub;
                  idx          <= '0;
                  result_reg   <= '0;
                  in_ready_reg <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               result_reg[int'(idx)*N +: N] <= add_result;
               carry <= add_cout;
               idx   <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  // Signed overflow: operands agree in sign and the sum's sign differs.
                  cout_reg      <= add_cout;
                  overflow_reg  <= (op_a[W-1] ~^ op_b[W-1]) & (add_result[N-1] ^ op_a[W-1]);
                  idx           <= '0;
                  out_valid_reg <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   // in_ready is held low while reset is asserted and rises as soon as it releases.
   assign in_ready  = in_ready_reg & rst_n;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign cout      = cout_reg;
   assign overflow  = overflow_reg;

endmodule
